bit_collect: RTL and testbench

BIT_COLLECT -- requirements
Module: bit_collect

---
 rtl/bit_collect.sv | 154 +++++++++++++++
 tb/tb_bit_collect.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bit_collect.sv
`default_nettype none
// ============================================================================
//  Module      : bit_collect
//  Description : Collects two MSB-first serial characters (x, y) into 8-bit
//                words after a start strobe, compares them serially while
//                the bits arrive, and presents X, Y and GT/EQ/LT with a
//                one-cycle Done pulse nine cycles after St.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_collect (
    input  logic       CLK,
    input  logic       RST,
    input  logic       St,
    input  logic       x,
    input  logic       y,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic       Done,
    output logic       Busy,
    output logic       GT,
    output logic       EQ,
    output logic       LT
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RECV = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_LAST_BIT = 3'd7;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_sx;
    logic [7:0] r_sy;
    logic       r_decided;
    logic       r_cand_gt;
    logic       r_cand_lt;

    // Registered copies of every output
    logic [7:0] r_x_out;
    logic [7:0] r_y_out;
    logic       r_done;
    logic       r_busy;
    logic       r_gt;
    logic       r_eq;
    logic       r_lt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic [7:0] w_sx_nxt;
    logic [7:0] w_sy_nxt;
    logic       w_decided_nxt;
    logic       w_gt_nxt;
    logic       w_lt_nxt;
    logic       w_start;
    logic       w_last;

    // A new transfer may only begin from IDLE or DONE; St in RECV is ignored
    assign w_start = St && ((r_state == c_IDLE) || (r_state == c_DONE));

    // Final sample of a transfer: the words and verdict are complete here
    assign w_last  = (r_state == c_RECV) && (r_cnt == c_LAST_BIT);

    // Shift the newly arriving bit into the LSB
    assign w_sx_nxt = {r_sx[6:0], x};
    assign w_sy_nxt = {r_sy[6:0], y};

    // Serial comparator: the first differing bit (MSB-first) decides and
    // is then frozen, so later bits cannot change the verdict.
    assign w_decided_nxt = r_decided | (x ^ y);
    assign w_gt_nxt      = r_decided ? r_cand_gt : (x & ~y);
    assign w_lt_nxt      = r_decided ? r_cand_lt : (~x & y);

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = St ? c_RECV : c_IDLE;
            c_RECV:  w_state_nxt = (r_cnt == c_LAST_BIT) ? c_DONE : c_RECV;
            c_DONE:  w_state_nxt = St ? c_RECV : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State, counter, shift registers and serial-compare bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_IDLE;
            r_cnt     <= 3'd0;
            r_sx      <= 8'h00;
            r_sy      <= 8'h00;
            r_decided <= 1'b0;
            r_cand_gt <= 1'b0;
            r_cand_lt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt     <= 3'd0;
                r_decided <= 1'b0;
                r_cand_gt <= 1'b0;
                r_cand_lt <= 1'b0;
            end else if (r_state == c_RECV) begin
                r_cnt     <= r_cnt + 3'd1;
                r_sx      <= w_sx_nxt;
                r_sy      <= w_sy_nxt;
                r_decided <= w_decided_nxt;
                r_cand_gt <= w_gt_nxt;
                r_cand_lt <= w_lt_nxt;
            end
        end
    end

    // Output registers: status follows the next state, results load on the
    // final sample so they are visible in the DONE cycle and held after.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x_out <= 8'h00;
            r_y_out <= 8'h00;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == c_DONE);
            r_busy <= (w_state_nxt == c_RECV);
            if (w_last) begin
                r_x_out <= w_sx_nxt;
                r_y_out <= w_sy_nxt;
                r_gt    <= w_gt_nxt;
                r_lt    <= w_lt_nxt;
                r_eq    <= ~w_decided_nxt;
            end
        end
    end

    assign X    = r_x_out;
    assign Y    = r_y_out;
    assign Done = r_done;
    assign Busy = r_busy;
    assign GT   = r_gt;
    assign EQ   = r_eq;
    assign LT   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_bit_collect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_collect
//  Description : Scoreboard bench for bit_collect. Stimulus pushes expected
//                results; a negedge monitor pops them on each Done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_collect;

    logic       CLK;
    logic       RST;
    logic       St;
    logic       x;
    logic       y;
    logic [7:0] X;
    logic [7:0] Y;
    logic       Done;
    logic       Busy;
    logic       GT;
    logic       EQ;
    logic       LT;

    bit_collect dut (
        .CLK  (CLK),
        .RST  (RST),
        .St   (St),
        .x    (x),
        .y    (y),
        .X    (X),
        .Y    (Y),
        .Done (Done),
        .Busy (Busy),
        .GT   (GT),
        .EQ   (EQ),
        .LT   (LT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] ex;
        logic [7:0] ey;
        logic       gt;
        logic       eq;
        logic       lt;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: each Done pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (Done === 1'b1) begin
            chk("done_busy_exclusive", {31'd0, Busy}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("X", {24'd0, X}, {24'd0, e.ex});
                chk("Y", {24'd0, Y}, {24'd0, e.ey});
                chk("GT", {31'd0, GT}, {31'd0, e.gt});
                chk("EQ", {31'd0, EQ}, {31'd0, e.eq});
                chk("LT", {31'd0, LT}, {31'd0, e.lt});
            end
        end
    end

    // Caller is one step after a posedge (cycle n); returns in cycle n+9
    task automatic xfer(input logic [7:0] xv, input logic [7:0] yv,
                        input logic g, input logic e, input logic l, input int st_at);
        exp_t ent;
        ent.ex = xv; ent.ey = yv; ent.gt = g; ent.eq = e; ent.lt = l;
        ent.cyc = cyc + 9;
        q.push_back(ent);
        St = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) begin
            St = (i == st_at);
            x  = xv[7-i];
            y  = yv[7-i];
            chk("busy_in_recv", {31'd0, Busy}, 32'd1);
            @(posedge CLK); #1;
        end
        St = 1'b0;
    endtask

    task automatic idle(input int n);
        St = 1'b0;
        for (int i = 0; i < n; i++) begin
            x = 1'($urandom);
            y = 1'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        RST = 1'b1; St = 1'b0; x = 1'b0; y = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset values
        chk("rst_X",    {24'd0, X}, 32'h00);
        chk("rst_Y",    {24'd0, Y}, 32'h00);
        chk("rst_EQ",   {31'd0, EQ}, 32'd1);
        chk("rst_GT",   {31'd0, GT}, 32'd0);
        chk("rst_LT",   {31'd0, LT}, 32'd0);
        chk("rst_Done", {31'd0, Done}, 32'd0);
        chk("rst_Busy", {31'd0, Busy}, 32'd0);
        idle(2);

        xfer(8'h41, 8'h42, 1'b0, 1'b0, 1'b1, -1);   // 'A' < 'B'
        idle(3);
        xfer(8'h7A, 8'h61, 1'b1, 1'b0, 1'b0, -1);   // 'z' > 'a'
        idle(3);
        xfer(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, -1);   // MSB decides, rest oppose
        idle(3);
        xfer(8'h55, 8'h55, 1'b0, 1'b1, 1'b0, -1);   // equal
        idle(20);
        chk("hold_X",    {24'd0, X}, 32'h55);
        chk("hold_Y",    {24'd0, Y}, 32'h55);
        chk("hold_EQ",   {31'd0, EQ}, 32'd1);
        chk("hold_GT",   {31'd0, GT}, 32'd0);
        chk("hold_Busy", {31'd0, Busy}, 32'd0);

        // Back-to-back: second St lands in the DONE cycle of the first
        xfer(8'hAA, 8'h0F, 1'b1, 1'b0, 1'b0, -1);
        xfer(8'h30, 8'h39, 1'b0, 1'b0, 1'b1, -1);
        idle(3);

        // St re-pulsed at the third RECV cycle is ignored
        xfer(8'hC3, 8'h3C, 1'b1, 1'b0, 1'b0, 2);
        idle(3);

        // Reset in the fourth RECV cycle aborts the transfer silently
        rx = 8'hE7; ry = 8'h18;
        St = 1'b1;
        @(posedge CLK); #1;
        St = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = rx[7-i];
            y = ry[7-i];
            if (i == 3) RST = 1'b1;
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        chk("abort_Busy", {31'd0, Busy}, 32'd0);
        chk("abort_Done", {31'd0, Done}, 32'd0);
        chk("abort_X",    {24'd0, X}, 32'h00);
        chk("abort_Y",    {24'd0, Y}, 32'h00);
        chk("abort_EQ",   {31'd0, EQ}, 32'd1);
        idle(12);
        chk("abort_hold_X",  {24'd0, X}, 32'h00);
        chk("abort_hold_EQ", {31'd0, EQ}, 32'd1);

        xfer(8'h20, 8'h7E, 1'b0, 1'b0, 1'b1, -1);
        idle(5);

        chk("pending_results", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
